// File: rtl/bike_pkg.sv
// bike_pkg: shared defaults for the bike computer odometer slice.
//   CIRC_W_DEF      default width of the circumference input (cm per revolution)
//   UNIT_CM_DEF     default number of cm in one distance unit (100 m)
//   DIST_W_DEF      default width of the trip/total distance counters
//   LOCKOUT_CYC_DEF default reed lockout length in clock cycles
//   cm_width()      bits needed for the cm remainder, which must hold UNIT_CM-1 + 2**CIRC_W-1
//   CM_W_DEF        cm_width() applied to the defaults
package bike_pkg;

    localparam int CIRC_W_DEF      = 32'sd8;
    localparam int UNIT_CM_DEF     = 32'sd10000;
    localparam int DIST_W_DEF      = 32'sd14;
    localparam int LOCKOUT_CYC_DEF = 32'sd20;

    // The largest transient remainder is (UNIT_CM-1) + (2**circ_w - 1), so the width
    // must represent UNIT_CM + 2**circ_w - 2, i.e. clog2(UNIT_CM + 2**circ_w - 1).
    function automatic int cm_width(input int unit_cm, input int circ_w);
        return $clog2(unit_cm + (32'sd1 << circ_w) - 32'sd1);
    endfunction

    localparam int CM_W_DEF = cm_width(UNIT_CM_DEF, CIRC_W_DEF);

endpackage

// File: rtl/odometer_counter_reed.sv
// reed_conditioner: turns the raw, asynchronous reed contact into one clean pulse per
// accepted wheel revolution.
//   clock    in   system clock
//   reset    in   synchronous, active-high; clears synchroniser, edge history and lockout
//   reed     in   raw reed contact (asynchronous)
//   pulse_o  out  one-cycle pulse per accepted rising edge
// A rising edge is accepted only while the lockout counter is idle; acceptance reloads the
// lockout with LOCKOUT_CYC and edges seen while it counts down are dropped, not queued.
module reed_conditioner #(
    parameter int LOCKOUT_CYC = 32'sd20
) (
    input  logic clock,
    input  logic reset,
    input  logic reed,
    output logic pulse_o
);

    localparam int LK_W = ($clog2(LOCKOUT_CYC + 32'sd1) < 32'sd1) ? 32'sd1
                                                                  : $clog2(LOCKOUT_CYC + 32'sd1);
    localparam logic [LK_W-1:0] LK_LOAD = LK_W'(LOCKOUT_CYC);
    localparam logic [LK_W-1:0] LK_ZERO = {LK_W{1'b0}};
    localparam logic [LK_W-1:0] LK_ONE  = LK_W'(1'b1);

    logic            sync1_r;
    logic            sync2_r;
    logic            prev_r;
    logic [LK_W-1:0] lockout_r;
    logic            edge_s;
    logic            accept_s;

    // Two-flop synchroniser followed by one flop of history for edge detection.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            prev_r  <= 1'b0;
        end else begin
            sync1_r <= reed;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
        end
    end

    // Rising edge on the synchronised contact, gated by an idle lockout.
    always_comb begin
        edge_s   = sync2_r & ~prev_r;
        accept_s = edge_s & (lockout_r == LK_ZERO);
    end

    // Lockout: reload on acceptance, otherwise count down to zero and rest there.
    always_ff @(posedge clock) begin
        if (reset) begin
            lockout_r <= LK_ZERO;
        end else if (accept_s) begin
            lockout_r <= LK_LOAD;
        end else if (lockout_r != LK_ZERO) begin
            lockout_r <= lockout_r - LK_ONE;
        end else begin
            lockout_r <= lockout_r;
        end
    end

    assign pulse_o = accept_s;

endmodule

// File: rtl/odometer_counter.sv
// odometer_counter: wheel-revolution odometer. Adds the wheel circumference to a cm
// remainder on every accepted reed pulse and converts whole units into trip/total counts.
//   clock       in   system clock
//   reset       in   synchronous, active-high; clears every output and the conditioner
//   reed        in   raw reed contact (asynchronous)
//   circ        in   wheel circumference in cm, sampled on the accumulate edge
//   enable      in   0 = accepted pulses are discarded (lockout still runs)
//   trip_clear  in   one-cycle request to clear trip and trip_ovf (wins over an increment)
//   trip        out  clearable distance in units
//   total       out  non-clearable distance in units
//   centimeters out  remainder cm toward the next unit (0..UNIT_CM-1)
//   unit_tick   out  one-cycle pulse accompanying each unit increment
//   trip_ovf    out  sticky trip overflow
//   total_ovf   out  sticky total overflow, cleared by reset only
// Because UNIT_CM >= 2**CIRC_W, one pulse can complete at most one unit, so a single
// subtraction keeps the remainder exact.
module odometer_counter
    import bike_pkg::*;
#(
    parameter int CIRC_W      = CIRC_W_DEF,
    parameter int UNIT_CM     = UNIT_CM_DEF,
    parameter int DIST_W      = DIST_W_DEF,
    parameter int CM_W        = CM_W_DEF,
    parameter int LOCKOUT_CYC = LOCKOUT_CYC_DEF,
    parameter int SATURATE    = 32'sd1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              reed,
    input  logic [CIRC_W-1:0] circ,
    input  logic              enable,
    input  logic              trip_clear,
    output logic [DIST_W-1:0] trip,
    output logic [DIST_W-1:0] total,
    output logic [CM_W-1:0]   centimeters,
    output logic              unit_tick,
    output logic              trip_ovf,
    output logic              total_ovf
);

    // Parameter sanity: a pulse must never complete more than one unit, and the remainder
    // must be wide enough for the pre-subtraction sum.
    if (UNIT_CM < (32'sd1 << CIRC_W)) begin : g_bad_unit_cm
        $error("odometer_counter: UNIT_CM must be >= 2**CIRC_W");
    end
    if (CM_W < cm_width(UNIT_CM, CIRC_W)) begin : g_bad_cm_w
        $error("odometer_counter: CM_W too narrow for UNIT_CM-1 + 2**CIRC_W-1");
    end

    localparam logic [CM_W:0]     UNIT_S    = (CM_W+1)'(UNIT_CM);
    localparam logic [DIST_W-1:0] DIST_ONES = {DIST_W{1'b1}};
    localparam logic [DIST_W-1:0] DIST_ZERO = {DIST_W{1'b0}};
    localparam logic [DIST_W-1:0] DIST_ONE  = DIST_W'(1'b1);

    // Next value of a distance counter on increment, with the overflow flag in the MSB.
    function automatic logic [DIST_W:0] bump(input logic [DIST_W-1:0] cnt);
        if (cnt == DIST_ONES) begin
            return {1'b1, (SATURATE != 32'sd0) ? DIST_ONES : DIST_ZERO};
        end else begin
            return {1'b0, cnt + DIST_ONE};
        end
    endfunction

    logic              pulse_s;
    logic              acc_s;
    logic              unit_s;
    logic [CM_W:0]     sum_s;
    logic [CM_W-1:0]   cm_next_s;
    logic [DIST_W:0]   trip_bump_s;
    logic [DIST_W:0]   total_bump_s;

    reed_conditioner #(
        .LOCKOUT_CYC (LOCKOUT_CYC)
    ) u_reed (
        .clock   (clock),
        .reset   (reset),
        .reed    (reed),
        .pulse_o (pulse_s)
    );

    // Accumulate circumference and decide whether a whole unit was completed.
    always_comb begin
        sum_s  = (CM_W+1)'(centimeters) + (CM_W+1)'(circ);
        acc_s  = pulse_s & enable;
        unit_s = acc_s & (sum_s >= UNIT_S);
        if (!acc_s) begin
            cm_next_s = centimeters;
        end else if (unit_s) begin
            cm_next_s = CM_W'(sum_s - UNIT_S);
        end else begin
            cm_next_s = CM_W'(sum_s);
        end
        trip_bump_s  = bump(trip);
        total_bump_s = bump(total);
    end

    // Remainder register and unit tick.
    always_ff @(posedge clock) begin
        if (reset) begin
            centimeters <= {CM_W{1'b0}};
            unit_tick   <= 1'b0;
        end else begin
            centimeters <= cm_next_s;
            unit_tick   <= unit_s;
        end
    end

    // Total counter: only reset clears it or its overflow flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            total     <= DIST_ZERO;
            total_ovf <= 1'b0;
        end else if (unit_s) begin
            total     <= total_bump_s[DIST_W-1:0];
            total_ovf <= total_ovf | total_bump_s[DIST_W];
        end else begin
            total     <= total;
            total_ovf <= total_ovf;
        end
    end

    // Trip counter: a clear request beats a coincident increment.
    always_ff @(posedge clock) begin
        if (reset) begin
            trip     <= DIST_ZERO;
            trip_ovf <= 1'b0;
        end else if (trip_clear) begin
            trip     <= DIST_ZERO;
            trip_ovf <= 1'b0;
        end else if (unit_s) begin
            trip     <= trip_bump_s[DIST_W-1:0];
            trip_ovf <= trip_ovf | trip_bump_s[DIST_W];
        end else begin
            trip     <= trip;
            trip_ovf <= trip_ovf;
        end
    end

endmodule

// File: tb/tb_odometer_counter.sv
// tb_odometer_counter: directed bench for odometer_counter. Three instances share the
// stimulus: default parameters, and a small UNIT_CM=256 / DIST_W=4 build in saturating and
// wrapping flavours for overflow behaviour.
module tb_odometer_counter;

    logic       clock;
    logic       reset;
    logic       reed;
    logic [7:0] circ;
    logic       enable;
    logic       trip_clear;

    logic [13:0] d_trip, d_total, d_cm;
    logic        d_tick, d_tovf, d_govf;
    logic [3:0]  s_trip, s_total, w_trip, w_total;
    logic [8:0]  s_cm, w_cm;
    logic        s_tick, s_tovf, s_govf, w_tick, w_tovf, w_govf;

    int n_checks = 0;
    int n_errors = 0;
    int tick_seen = 0;
    int tick_base;

    odometer_counter dut (
        .clock(clock), .reset(reset), .reed(reed), .circ(circ), .enable(enable),
        .trip_clear(trip_clear), .trip(d_trip), .total(d_total), .centimeters(d_cm),
        .unit_tick(d_tick), .trip_ovf(d_tovf), .total_ovf(d_govf)
    );

    odometer_counter #(.UNIT_CM(256), .DIST_W(4), .CM_W(9), .SATURATE(1)) dut_s (
        .clock(clock), .reset(reset), .reed(reed), .circ(circ), .enable(enable),
        .trip_clear(trip_clear), .trip(s_trip), .total(s_total), .centimeters(s_cm),
        .unit_tick(s_tick), .trip_ovf(s_tovf), .total_ovf(s_govf)
    );

    odometer_counter #(.UNIT_CM(256), .DIST_W(4), .CM_W(9), .SATURATE(0)) dut_w (
        .clock(clock), .reset(reset), .reed(reed), .circ(circ), .enable(enable),
        .trip_clear(trip_clear), .trip(w_trip), .total(w_total), .centimeters(w_cm),
        .unit_tick(w_tick), .trip_ovf(w_tovf), .total_ovf(w_govf)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Count unit ticks of the default instance, sampled away from the active edge.
    always @(negedge clock) begin
        if (d_tick) tick_seen <= tick_seen + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reed       = 1'b0;
        trip_clear = 1'b0;
        reset      = 1'b1;
        repeat (2) @(negedge clock);
        reset      = 1'b0;
        @(negedge clock);
    endtask

    // Reed high for hi cycles then low for gap cycles; starts and ends on a negedge.
    task automatic reed_pulse(input int hi, input int gap);
        reed = 1'b1;
        repeat (hi) @(negedge clock);
        reed = 1'b0;
        repeat (gap) @(negedge clock);
    endtask

    initial begin
        reset = 1'b1; reed = 1'b0; circ = 8'd0; enable = 1'b1; trip_clear = 1'b0;
        @(negedge clock);
        do_reset();
        chk("rst_trip", d_trip, 0);
        chk("rst_total", d_total, 0);
        chk("rst_cm", d_cm, 0);
        chk("rst_tick", d_tick, 0);
        chk("rst_tovf", d_tovf, 0);
        chk("rst_govf", d_govf, 0);

        // 1: circ=200, 50 pulses -> one unit; latency of 3 edges from first reed=1 sample.
        circ = 8'd200;
        tick_base = tick_seen;
        reed = 1'b1;
        @(negedge clock);              // after edge k
        @(negedge clock);              // after edge k+1
        chk("t1_lat_pre", d_cm, 0);
        @(negedge clock);              // after edge k+2
        chk("t1_lat_upd", d_cm, 200);
        reed = 1'b0;
        repeat (37) @(negedge clock);
        for (int i = 0; i < 49; i++) reed_pulse(3, 37);
        chk("t1_trip", d_trip, 1);
        chk("t1_total", d_total, 1);
        chk("t1_cm", d_cm, 0);
        chk("t1_ticks", tick_seen - tick_base, 1);

        // 2: circ=255, 40 pulses = 10200 cm -> 1 unit, 200 cm remainder carried.
        do_reset();
        circ = 8'd255;
        tick_base = tick_seen;
        for (int i = 0; i < 40; i++) reed_pulse(3, 37);
        chk("t2_trip", d_trip, 1);
        chk("t2_total", d_total, 1);
        chk("t2_cm", d_cm, 200);
        chk("t2_ticks", tick_seen - tick_base, 1);

        // 3: bounce 5 cycles apart is locked out; pulse 25 cycles after the first counts.
        do_reset();
        circ = 8'd100;
        for (int i = 0; i < 3; i++) reed_pulse(2, 3);
        repeat (10) @(negedge clock);
        chk("t3_bounce", d_cm, 100);
        reed_pulse(2, 30);
        chk("t3_after", d_cm, 200);

        // 4: small build, 21 pulses of 255 cm -> 20 units into a 4-bit counter.
        do_reset();
        circ = 8'd255;
        for (int i = 0; i < 21; i++) reed_pulse(3, 37);
        chk("t4_sat_trip", s_trip, 15);
        chk("t4_sat_total", s_total, 15);
        chk("t4_sat_tovf", s_tovf, 1);
        chk("t4_sat_govf", s_govf, 1);
        chk("t4_sat_cm", s_cm, 235);
        chk("t4_wrap_trip", w_trip, 4);
        chk("t4_wrap_total", w_total, 4);
        chk("t4_wrap_tovf", w_tovf, 1);
        chk("t4_wrap_govf", w_govf, 1);
        // Standalone trip_clear drops trip and trip_ovf but not total or total_ovf.
        trip_clear = 1'b1;
        @(negedge clock);
        trip_clear = 1'b0;
        chk("t4_clr_trip", s_trip, 0);
        chk("t4_clr_tovf", s_tovf, 0);
        chk("t4_clr_total", s_total, 15);
        chk("t4_clr_govf", s_govf, 1);

        // 5: trip=total=3, then trip_clear on the same edge as the 4th increment.
        do_reset();
        circ = 8'd255;
        for (int i = 0; i < 4; i++) reed_pulse(3, 37);
        chk("t5_pre_trip", s_trip, 3);
        chk("t5_pre_total", s_total, 3);
        reed = 1'b1;
        @(negedge clock);
        @(negedge clock);
        trip_clear = 1'b1;             // present at edge k+2
        @(negedge clock);
        trip_clear = 1'b0;
        reed = 1'b0;
        repeat (37) @(negedge clock);
        chk("t5_trip", s_trip, 0);
        chk("t5_total", s_total, 4);
        chk("t5_tovf", s_tovf, 0);
        chk("t5_cm", s_cm, 251);
        enable = 1'b0;
        for (int i = 0; i < 10; i++) reed_pulse(3, 37);
        chk("t5_dis_trip", s_trip, 0);
        chk("t5_dis_total", s_total, 4);
        chk("t5_dis_cm", s_cm, 251);
        enable = 1'b1;

        // 6: reset in mid-lockout at 9900 cm; a pulse 2 cycles after release is accepted.
        do_reset();
        circ = 8'd225;
        for (int i = 0; i < 43; i++) reed_pulse(3, 37);
        reed = 1'b1;
        repeat (3) @(negedge clock);   // 44th pulse accepted, lockout running
        repeat (5) @(negedge clock);
        chk("t6_pre_cm", d_cm, 9900);
        reset = 1'b1;
        reed  = 1'b0;
        @(negedge clock);
        chk("t6_rst_cm", d_cm, 0);
        chk("t6_rst_trip", d_trip, 0);
        chk("t6_rst_total", d_total, 0);
        chk("t6_rst_tick", d_tick, 0);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        reed_pulse(3, 10);
        chk("t6_post_cm", d_cm, 225);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
